itof: RTL

//  Signed 32-bit two's-complement integer -> IEEE-754 single conversion (FPU itof op).

---
 rtl/itof.sv | 126 ++++++++++++
 1 files changed

// File: rtl/itof.sv
// Signed 32-bit integer to IEEE-754 single conversion; optional macro ITOF_RNE_EN selects round-to-nearest-even.
// Latency 3 cycles, one operand accepted per cycle; valid_in only tags data, result in y/valid_out.
// No backpressure: the pipeline advances every cycle and valid_out cannot be stalled.
module itof #(
    parameter int NSTAGE = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        valid_in,
    output logic [31:0] y,
    output logic        valid_out
);

    generate
        if (NSTAGE != 3) begin : g_nstage_chk
            $error("itof: only NSTAGE = 3 is supported");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: sign and magnitude. 0x80000000 negates to itself, which is
    // exactly the unsigned magnitude 2^31.
    // ------------------------------------------------------------------
    logic        s1_sign;
    logic [31:0] s1_abs;
    logic        s1_vld;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_sign <= 1'b0;
            s1_abs  <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_sign <= x[31];
            s1_abs  <= x[31] ? (~x + 32'd1) : x;
            s1_vld  <= valid_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: locate the leading one and normalise.
    // ------------------------------------------------------------------
    logic [4:0] msb;
    logic [4:0] lzc;

    always_comb begin
        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (s1_abs[i]) msb = 5'(i);
        end
    end

    assign lzc = 5'd31 - msb;

    logic        s2_sign;
    logic [7:0]  s2_exp;
    logic        s2_zero;
    logic [30:0] s2_frac;   // hidden bit dropped; it is always 1 unless s2_zero
    logic        s2_vld;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_zero <= 1'b0;
            s2_frac <= '0;
            s2_vld  <= 1'b0;
        end else begin
            s2_sign <= s1_sign;
            s2_exp  <= 8'd127 + {3'd0, msb};
            s2_zero <= (s1_abs == 32'd0);
            s2_frac <= 31'(s1_abs << lzc);
            s2_vld  <= s1_vld;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round and pack. Magnitudes up to 2^31 keep e <= 158, so
    // the exponent never reaches the Inf/NaN encoding.
    // ------------------------------------------------------------------
    logic [22:0] mant;
    logic        guard;
    logic        round_up;
    logic [23:0] mant_inc;
    logic [22:0] mant_out;
    logic [7:0]  exp_out;

    assign mant  = s2_frac[30:8];
    assign guard = s2_frac[7];

`ifdef ITOF_RNE_EN
    logic sticky;
    assign sticky   = |s2_frac[6:0];
    assign round_up = guard & (sticky | mant[0]);
`else
    // Half away from zero: the guard bit alone decides.
    assign round_up = guard;
`endif

    assign mant_inc = {1'b0, mant} + 24'd1;

    always_comb begin
        mant_out = mant;
        exp_out  = s2_exp;
        if (round_up) begin
            if (mant_inc[23]) begin
                mant_out = '0;
                exp_out  = s2_exp + 8'd1;
            end else begin
                mant_out = mant_inc[22:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            y         <= '0;
            valid_out <= 1'b0;
        end else begin
            y         <= s2_zero ? 32'd0 : {s2_sign, exp_out, mant_out};
            valid_out <= s2_vld;
        end
    end

endmodule
